// File: rtl/pool_window_feeder.sv
// rtl/pool_window_feeder.sv - 2x2 stride-2 window collector feeding the average pooling stage
module pool_window_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int IFM_WIDTH  = 28,
    parameter int IFM_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  pool_enable,
    output logic [DATA_WIDTH-1:0] pool_data_out_1,
    output logic [DATA_WIDTH-1:0] pool_data_out_2,
    output logic [DATA_WIDTH-1:0] pool_data_out_3,
    output logic [DATA_WIDTH-1:0] pool_data_out_4,
    output logic                  frame_done
);

    localparam int COL_W = $clog2(IFM_WIDTH);
    localparam int ROW_W = $clog2(IFM_HEIGHT);

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] line_buf [IFM_WIDTH];

    logic             col_last;
    logic             row_last;
    logic             odd_row;
    logic             odd_col;
    logic             window_fire;
    logic [COL_W-1:0] col_left;

    assign col_last    = (col == COL_W'(IFM_WIDTH - 1));
    assign row_last    = (row == ROW_W'(IFM_HEIGHT - 1));
    assign odd_row     = row[0];
    assign odd_col     = col[0];
    assign window_fire = data_valid && odd_row && odd_col;
    assign col_left    = col - COL_W'(1);

    // Even rows only write, odd rows only read, so the buffer needs no reset or bypass.
    always_ff @(posedge clk) begin
        if (data_valid && !odd_row) begin
            line_buf[col] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col             <= '0;
            row             <= '0;
            hold            <= '0;
            pool_enable     <= 1'b0;
            frame_done      <= 1'b0;
            pool_data_out_1 <= '0;
            pool_data_out_2 <= '0;
            pool_data_out_3 <= '0;
            pool_data_out_4 <= '0;
        end else begin
            pool_enable <= window_fire;
            frame_done  <= window_fire && row_last && col_last;

            if (data_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end

                if (odd_row && !odd_col) begin
                    hold <= data_in;
                end
            end

            // Window outputs hold their value between strobes.
            if (window_fire) begin
                pool_data_out_1 <= line_buf[col_left];
                pool_data_out_2 <= line_buf[col];
                pool_data_out_3 <= hold;
                pool_data_out_4 <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
// tb/tb_pool_window_feeder.sv - scoreboard bench for pool_window_feeder (4x4 directed, 28x28 random)
module tb_pool_window_feeder;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        logic [31:0] d4;
        logic        fd;
    } win_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        dv_s = 1'b0;
    logic [31:0] din_s = '0;
    logic        pe_s, fd_s;
    logic [31:0] o1_s, o2_s, o3_s, o4_s;

    logic        dv_b = 1'b0;
    logic [31:0] din_b = '0;
    logic        pe_b, fd_b;
    logic [31:0] o1_b, o2_b, o3_b, o4_b;

    int tests = 0;
    int failed = 0;

    win_t q_s[$];
    win_t q_b[$];
    win_t last_s = '{default: '0};
    win_t last_b = '{default: '0};

    logic        acc_v_s = 1'b0, acc_v_b = 1'b0;
    logic [31:0] acc_d_s = '0, acc_d_b = '0;

    logic [31:0] img [28][28];

    always #5 clk = ~clk;

    pool_window_feeder #(.DATA_WIDTH(32), .IFM_WIDTH(4), .IFM_HEIGHT(4)) dut_s (
        .clk(clk), .reset(reset), .data_valid(dv_s), .data_in(din_s),
        .pool_enable(pe_s), .pool_data_out_1(o1_s), .pool_data_out_2(o2_s),
        .pool_data_out_3(o3_s), .pool_data_out_4(o4_s), .frame_done(fd_s)
    );

    pool_window_feeder dut_b (
        .clk(clk), .reset(reset), .data_valid(dv_b), .data_in(din_b),
        .pool_enable(pe_b), .pool_data_out_1(o1_b), .pool_data_out_2(o2_b),
        .pool_data_out_3(o3_b), .pool_data_out_4(o4_b), .frame_done(fd_b)
    );

    // Values actually accepted at the last rising edge, used to verify 1-cycle latency.
    always @(posedge clk) begin
        acc_v_s <= dv_s;
        acc_d_s <= din_s;
        acc_v_b <= dv_b;
        acc_d_b <= din_b;
    end

    always @(negedge clk) begin
        win_t w;
        if (!reset) begin
            last_s = '{default: '0};
        end else if (pe_s) begin
            tests++;
            if (q_s.size() == 0) begin
                failed++;
                $display("FAIL small_extra_strobe got %0d,%0d,%0d,%0d expected none", o1_s, o2_s, o3_s, o4_s);
            end else begin
                w = q_s.pop_front();
                if (o1_s !== w.d1 || o2_s !== w.d2 || o3_s !== w.d3 || o4_s !== w.d4 || fd_s !== w.fd) begin
                    failed++;
                    $display("FAIL small_window got %0d,%0d,%0d,%0d fd=%0b expected %0d,%0d,%0d,%0d fd=%0b",
                             o1_s, o2_s, o3_s, o4_s, fd_s, w.d1, w.d2, w.d3, w.d4, w.fd);
                end
                tests++;
                if (!(acc_v_s && acc_d_s == w.d4)) begin
                    failed++;
                    $display("FAIL small_latency accepted v=%0b d=%0d expected v=1 d=%0d", acc_v_s, acc_d_s, w.d4);
                end
                last_s = w;
            end
        end else begin
            tests++;
            if (fd_s !== 1'b0 || o1_s !== last_s.d1 || o2_s !== last_s.d2 || o3_s !== last_s.d3 || o4_s !== last_s.d4) begin
                failed++;
                $display("FAIL small_hold got %0d,%0d,%0d,%0d fd=%0b expected %0d,%0d,%0d,%0d fd=0",
                         o1_s, o2_s, o3_s, o4_s, fd_s, last_s.d1, last_s.d2, last_s.d3, last_s.d4);
            end
        end
    end

    always @(negedge clk) begin
        win_t w;
        if (reset && pe_b) begin
            tests++;
            if (q_b.size() == 0) begin
                failed++;
                $display("FAIL big_extra_strobe got %0h expected none", o4_b);
            end else begin
                w = q_b.pop_front();
                if (o1_b !== w.d1 || o2_b !== w.d2 || o3_b !== w.d3 || o4_b !== w.d4 || fd_b !== w.fd) begin
                    failed++;
                    $display("FAIL big_window got %0h,%0h,%0h,%0h fd=%0b expected %0h,%0h,%0h,%0h fd=%0b",
                             o1_b, o2_b, o3_b, o4_b, fd_b, w.d1, w.d2, w.d3, w.d4, w.fd);
                end
                tests++;
                if (!(acc_v_b && acc_d_b == w.d4)) begin
                    failed++;
                    $display("FAIL big_latency accepted v=%0b d=%0h expected v=1 d=%0h", acc_v_b, acc_d_b, w.d4);
                end
                last_b = w;
            end
        end else if (reset) begin
            tests++;
            if (fd_b !== 1'b0 || o4_b !== last_b.d4 || o1_b !== last_b.d1) begin
                failed++;
                $display("FAIL big_hold got %0h,%0h fd=%0b expected %0h,%0h fd=0", o1_b, o4_b, fd_b, last_b.d1, last_b.d4);
            end
        end
    end

    task automatic push_s(input int a, input int b, input int c, input int d, input logic fd);
        win_t w;
        w.d1 = a; w.d2 = b; w.d3 = c; w.d4 = d; w.fd = fd;
        q_s.push_back(w);
    endtask

    task automatic push_frame_s(input int base);
        push_s(base + 1, base + 2, base + 5, base + 6, 1'b0);
        push_s(base + 3, base + 4, base + 7, base + 8, 1'b0);
        push_s(base + 9, base + 10, base + 13, base + 14, 1'b0);
        push_s(base + 11, base + 12, base + 15, base + 16, 1'b1);
    endtask

    task automatic pix_s(input int v);
        dv_s = 1'b1;
        din_s = v;
        @(posedge clk); #1;
        dv_s = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero_s(input string name);
        tests++;
        if (pe_s !== 1'b0 || fd_s !== 1'b0 || o1_s !== 0 || o2_s !== 0 || o3_s !== 0 || o4_s !== 0) begin
            failed++;
            $display("FAIL %s got pe=%0b fd=%0b %0d,%0d,%0d,%0d expected all 0", name, pe_s, fd_s, o1_s, o2_s, o3_s, o4_s);
        end
    endtask

    task automatic check_empty(input string name, input int sz);
        tests++;
        if (sz != 0) begin
            failed++;
            $display("FAIL %s got %0d windows outstanding expected 0", name, sz);
        end
    endtask

    initial begin
        win_t w;
        // Reset state
        idle(2);
        @(negedge clk);
        check_zero_s("reset_state_small");
        tests++;
        if (pe_b !== 1'b0 || fd_b !== 1'b0 || o1_b !== 0 || o4_b !== 0) begin
            failed++;
            $display("FAIL reset_state_big got pe=%0b fd=%0b %0h,%0h expected 0", pe_b, fd_b, o1_b, o4_b);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        idle(1);

        // Continuous frame
        push_frame_s(0);
        for (int i = 1; i <= 16; i++) pix_s(i);
        idle(3);
        check_empty("continuous_frame", q_s.size());

        // Alternating valid with a long gap between pixels 5 and 6
        push_frame_s(0);
        for (int i = 1; i <= 16; i++) begin
            pix_s(i);
            idle(i == 5 ? 5 : 1);
        end
        idle(3);
        check_empty("gapped_frame", q_s.size());

        // Back-to-back frames with no idle cycle
        push_frame_s(0);
        push_frame_s(100);
        for (int i = 1; i <= 16; i++) pix_s(i);
        for (int i = 101; i <= 116; i++) pix_s(i);
        idle(3);
        check_empty("back_to_back", q_s.size());

        // Reset after pixel 7; the only window from the aborted frame is (1,2,5,6)
        push_s(1, 2, 5, 6, 1'b0);
        for (int i = 1; i <= 7; i++) pix_s(i);
        reset = 1'b0;
        @(negedge clk);
        check_zero_s("mid_reset_cycle1");
        @(negedge clk);
        check_zero_s("mid_reset_cycle2");
        @(posedge clk); #1;
        reset = 1'b1;
        check_empty("pre_reset_window", q_s.size());
        push_frame_s(0);
        for (int i = 1; i <= 16; i++) pix_s(i);
        idle(3);
        check_empty("after_reset", q_s.size());

        // Default 28x28 frame with random data and occasional gaps
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r][c] = $urandom;
        for (int r = 1; r < 28; r += 2)
            for (int c = 1; c < 28; c += 2) begin
                w.d1 = img[r-1][c-1];
                w.d2 = img[r-1][c];
                w.d3 = img[r][c-1];
                w.d4 = img[r][c];
                w.fd = (r == 27 && c == 27);
                q_b.push_back(w);
            end
        tests++;
        if (q_b.size() != 196) begin
            failed++;
            $display("FAIL big_window_count got %0d expected 196", q_b.size());
        end
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                dv_b = 1'b1;
                din_b = img[r][c];
                @(posedge clk); #1;
                dv_b = 1'b0;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        idle(4);
        check_empty("big_frame", q_b.size());

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pool_window_feeder.md
Name: pool_window_feeder

Overview:
- Raster-order feature-map streamer that collects a 2x2, stride-2 window and presents its four pixels to the average pooling stage, together with a one-cycle pool_enable strobe.
- Sits between a convolution/activation output stream and the pooling stage.
- Buffers one even row in an internal line buffer.
- Pairs each even row with the following odd row to form the windows.

Parameters:
- DATA_WIDTH, 32, pixel word width (same arithmetic format as the pooling stage).
- IFM_WIDTH, 28, pixels per row; must be even and >= 2.
- IFM_HEIGHT, 28, rows per frame; must be even and >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- data_valid  input  1  data_in carries a valid pixel this cycle; no backpressure, every valid pixel is consumed.
- data_in  input  DATA_WIDTH  pixel, raster order, row-major.
- pool_enable  output  1  one-cycle strobe: pool_data_out_1..4 hold a new window.
- pool_data_out_1  output  DATA_WIDTH  window top-left.
- pool_data_out_2  output  DATA_WIDTH  window top-right.
- pool_data_out_3  output  DATA_WIDTH  window bottom-left.
- pool_data_out_4  output  DATA_WIDTH  window bottom-right.
- frame_done  output  1  one-cycle strobe coincident with the last window of a frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - col/row counters go to 0; odd-column holding register goes to 0.
  - pool_enable=0, frame_done=0, pool_data_out_1..4=0.
  - Line buffer contents need not be cleared.
- Counters:
  - col runs 0..IFM_WIDTH-1; row runs 0..IFM_HEIGHT-1.
  - Both advance only on cycles with data_valid=1.
  - col wraps to 0 and increments row at IFM_WIDTH-1.
  - row wraps to 0 at IFM_HEIGHT-1 with col=IFM_WIDTH-1 (end of frame).
  - The next frame starts immediately; no idle cycle is required.
- Even row (row[0]=0):
  - Each valid pixel is written to line_buf[col].
  - No output strobe.
- Odd row, even col: the valid pixel is latched into a holding register (bottom-left).
- Odd row, odd col (valid pixel) — registered outputs on the next clock edge:
  - pool_data_out_1 = line_buf[col-1]
  - pool_data_out_2 = line_buf[col]
  - pool_data_out_3 = holding register
  - pool_data_out_4 = data_in
  - pool_enable = 1
  - Latency: exactly 1 cycle from the accepted bottom-right pixel to pool_enable.
- Output hold: pool_enable=0 on every other cycle. pool_data_out_* hold their last window until the next strobe.
- frame_done: asserted in the same cycle as pool_enable for the window at row=IFM_HEIGHT-1, col=IFM_WIDTH-1.
- Throughput and count:
  - IFM_WIDTH/2 windows per odd row.
  - (IFM_WIDTH/2)*(IFM_HEIGHT/2) windows per frame.
  - Strobes are never closer than 2 cycles apart.
- data_valid gaps: any number of idle cycles may occur anywhere, including between the two pixels of a window pair. State and outputs are frozen during gaps.
- Read/write overlap: line_buf is read only on odd rows and written only on even rows, so there is no read/write collision.
- Reset mid-frame: partial windows are discarded. The next valid pixel after release is treated as row 0, col 0.
- Downstream timing: the pooling stage's result appears 3 cycles after pool_enable. That pipeline is not part of this block.

Test Plan:
- IFM_WIDTH=4, IFM_HEIGHT=4, pixels 1..16 continuous.
  - Expect 4 strobes, windows (1,2,5,6), (3,4,7,8), (9,10,13,14), (11,12,15,16).
  - Each strobe arrives 1 cycle after pixels 6, 8, 14, 16; frame_done only with the last window.
- Same frame with data_valid toggled 1/0 every cycle (and a 5-cycle gap between pixels 5 and 6) -> identical windows.
  - pool_enable follows the accepting edge of pixel 6/8/14/16 by 1 cycle.
  - Outputs are stable during gaps.
- Two back-to-back frames, pixels 1..16 then 101..116 with no idle cycle.
  - Second frame windows are (101,102,105,106) through (111,112,115,116).
  - Two frame_done pulses total.
- Assert reset=0 after pixel 7 for 2 cycles, then stream 1..16.
  - All outputs read 0 during reset.
  - Exactly 4 correct windows follow, with no stale window from the aborted frame.
- Default 28x28 frame, random data.
  - 196 strobes; each window is checked against the scoreboard.
  - Feeding the average pooling stage gives out = (tl+tr+bl+br)/4, 3 cycles after each strobe.
